// File: rtl/schoolbook_div.sv
// Unsigned restoring (schoolbook) divider, one dividend bit per clock, MSB first.
// A zero divisor spends a single cycle before DONE and reports all-ones quotient,
// the low NB dividend bits as remainder, and raises dbz.
module schoolbook_div #(
  parameter int NA = 1042,
  parameter int NB = 521
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NA-1:0] a,
  input  logic [NB-1:0] b,
  output logic [NA-1:0] q,
  output logic [NB-1:0] r,
  output logic          busy,
  output logic          done,
  output logic          dbz
);

  localparam int CW = (NA > 1) ? $clog2(NA) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // aq holds the dividend; quotient bits shift in from the bottom as dividend
  // bits leave the top, so after NA steps it holds the full quotient.
  logic [NA-1:0] aq;
  logic [NB-1:0] b_lat;
  logic [NB:0]   rem;
  logic [CW-1:0] cnt;

  logic [NB:0]   rem_nxt;
  logic          q_bit;
  logic          accept;
  logic          last_bit;

  // One restoring step: returns {quotient bit, new partial remainder}.
  // The partial remainder is always < divisor, so the shifted value fits NB+1 bits.
  function automatic logic [NB+1:0] restore_step(input logic [NB:0]   rem_in,
                                                 input logic          bit_in,
                                                 input logic [NB-1:0] div);
    logic [NB+1:0] shifted;
    shifted = {rem_in, bit_in};
    if (shifted >= {2'b00, div}) begin
      restore_step = {1'b1, (NB+1)'(shifted - {2'b00, div})};
    end else begin
      restore_step = {1'b0, (NB+1)'(shifted)};
    end
  endfunction

  assign accept   = (state == IDLE) && start;
  assign last_bit = (cnt == '0);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Restoring step for the current dividend bit.
  always_comb begin
    {q_bit, rem_nxt} = restore_step(rem, aq[NA-1], b_lat);
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (dbz || last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter and visible results; q and r change only on the cycle that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      q   <= '0;
      r   <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      cnt <= CW'(NA - 1);
      dbz <= (b == '0);
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
      if (dbz) begin
        q <= '1;
        r <= aq[NB-1:0];
      end else if (last_bit) begin
        q <= {aq[NA-2:0], q_bit};
        r <= rem_nxt[NB-1:0];
      end
    end
  end

  // Operand and partial-remainder datapath; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      aq    <= a;
      b_lat <= b;
      rem   <= '0;
    end else if (state == RUN) begin
      aq  <= {aq[NA-2:0], q_bit};
      rem <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_schoolbook_div.sv
// Bench for schoolbook_div: an arithmetic reference (/ and %) with cycle-level
// timing of busy/done, directed cases with literal results, and random back-to-back runs.
module tb_schoolbook_div;

  localparam int NA = 1042;
  localparam int NB = 521;
  localparam int N_RAND = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NA-1:0] a;
  logic [NB-1:0] b;
  logic [NA-1:0] q;
  logic [NB-1:0] r;
  logic          busy;
  logic          done;
  logic          dbz;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  schoolbook_div #(.NA(NA), .NB(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .dbz(dbz)
  );

  task automatic chk(input string name, input logic [NA-1:0] act, input logic [NA-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  // Reference model state, as seen just after each rising edge.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic          m_dbz  = 1'b0;
  logic          m_zero = 1'b0;
  logic [NA-1:0] m_q = '0;
  logic [NB-1:0] m_r = '0;
  logic [NA-1:0] p_q, p_a;
  logic [NB-1:0] p_r, p_b;
  longint        cyc = 0;
  longint        done_at = 0;
  logic [NA+NB-1:0] lhs;

  // Model update at each edge, then compare against the DUT 1 ns later.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_q    = '0;
      m_r    = '0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          p_a    = a;
          p_b    = b;
          m_zero = (b == '0);
          if (m_zero) begin
            p_q = '1;
            p_r = a[NB-1:0];
          end else begin
            p_q = a / NA'(b);
            p_r = NB'(a % NA'(b));
          end
          m_dbz   = m_zero;
          done_at = cyc + (m_zero ? 1 : NA);
          m_busy  = 1'b1;
        end
      end else if (cyc == done_at) begin
        m_q    = p_q;
        m_r    = p_r;
        m_done = 1'b1;
      end else if (cyc == done_at + 1) begin
        m_busy = 1'b0;
      end
    end
    #1;
    chk("busy", NA'(busy), NA'(m_busy));
    chk("done", NA'(done), NA'(m_done));
    chk("dbz",  NA'(dbz),  NA'(m_dbz));
    chk("q",    q,         m_q);
    chk("r",    NA'(r),    NA'(m_r));
    if (m_done && !m_zero) begin
      lhs = (NA+NB)'(q) * (NA+NB)'(p_b) + (NA+NB)'(r);
      chk("a_eq_qb_plus_r", NA'(lhs == (NA+NB)'(p_a)), NA'(1));
      chk("r_lt_b", NA'(r < p_b), NA'(1));
    end
  end

  // Wait for IDLE, then present one start pulse (accepted on the next edge).
  task automatic go(input logic [NA-1:0] av, input logic [NB-1:0] bv);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 2000);
    if (busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy stuck at %b", busy);
    end
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count rising edges until done is seen; bounded.
  task automatic wait_done(input int limit, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    while (cycles < limit && !seen) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  function automatic logic [NA-1:0] rand_wide(input int nbits);
    logic [NA-1:0] v;
    v = '0;
    for (int i = 0; i < NA; i++) begin
      if (i < nbits) v[i] = 1'($urandom_range(0, 1));
    end
    if (nbits > 0) v[nbits-1] = 1'b1;
    return v;
  endfunction

  initial begin
    int            lat;
    int            pulses;
    logic [NA-1:0] q_lit;

    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_busy", NA'(busy), '0);
    chk("reset_done", NA'(done), '0);
    chk("reset_q",    q,         '0);
    chk("reset_r",    NA'(r),    '0);
    chk("reset_dbz",  NA'(dbz),  '0);

    // 100 / 7
    go(NA'(100), NB'(7));
    wait_done(NA + 10, lat);
    chk("lat_100_7", NA'(lat), NA'(NA));
    chk("q_100_7",   q,        NA'(14));
    chk("r_100_7",   NA'(r),   NA'(2));
    chk("dbz_100_7", NA'(dbz), '0);

    // all-ones / 1
    go('1, NB'(1));
    wait_done(NA + 10, lat);
    chk("q_max_1", q,      '1);
    chk("r_max_1", NA'(r), '0);

    // all-ones / (2^NB - 1) = 2^NB + 1
    go('1, '1);
    wait_done(NA + 10, lat);
    q_lit     = '0;
    q_lit[NB] = 1'b1;
    q_lit[0]  = 1'b1;
    chk("q_max_bmax", q,      q_lit);
    chk("r_max_bmax", NA'(r), '0);

    // divide by zero, then a normal division
    go(NA'(5), NB'(0));
    wait_done(20, lat);
    chk("lat_dbz", NA'(lat), NA'(1));
    chk("q_dbz",   q,        '1);
    chk("r_dbz",   NA'(r),   NA'(5));
    chk("dbz_set", NA'(dbz), NA'(1));
    go(NA'(9), NB'(3));
    wait_done(NA + 10, lat);
    chk("q_9_3",     q,        NA'(3));
    chk("r_9_3",     NA'(r),   '0);
    chk("dbz_clear", NA'(dbz), '0);

    // second start while busy is ignored
    go(NA'(100), NB'(7));
    repeat (9) @(negedge clk);
    a     = NA'(1);
    b     = NB'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(NA + 10, lat);
    chk("q_ignore", q,      NA'(14));
    chk("r_ignore", NA'(r), NA'(2));

    // reset mid-run, with a start presented during reset
    go(NA'(100), NB'(7));
    repeat (499) @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    a     = NA'(1);
    b     = NB'(1);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    chk("abort_busy", NA'(busy), '0);
    chk("abort_q",    q,         '0);
    chk("abort_r",    NA'(r),    '0);
    pulses = 0;
    repeat (NA + 20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", NA'(pulses), '0);
    go(NA'(9), NB'(3));
    wait_done(NA + 10, lat);
    chk("q_after_abort", q,      NA'(3));
    chk("r_after_abort", NA'(r), '0);

    // random back-to-back: start held high, operands scrambled while busy
    for (int i = 0; i < N_RAND; i++) begin
      @(negedge clk);
      a     = rand_wide($urandom_range(1, NA));
      b     = NB'(rand_wide($urandom_range(1, NB)));
      start = 1'b1;
      repeat (2) @(negedge clk);
      a = rand_wide($urandom_range(0, NA));
      b = NB'(rand_wide($urandom_range(0, NB)));
      wait_done(NA + 10, lat);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
